seg_add_acc: RTL and testbench

Parametrised multi-cycle segmented adder with an accumulate mode, the sequential successor to the team's structural ripple-carry adders. It adds two WIDTH-bit operands one SEG-bit segment per clock through a single SEG-bit ripple-carry slice and a registered inter-segment carry, trading latency for area. An optional accumulate mode feeds back the previous result in place of operand `b`, for dot-product style summation in the TPU datapath.

---
 rtl/seg_add_acc_if.sv | 25 ++
 rtl/seg_add_acc.sv | 102 ++++++++++
 tb/tb_seg_add_acc.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_add_acc_if.sv
// Handshake/data bundle between a requester and the segmented adder.
interface seg_add_acc_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             acc;
    logic             acc_clr;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   sum;

    modport master (
        output start, a, b, cin, acc, acc_clr,
        input  busy, done, sum
    );

    modport slave (
        input  start, a, b, cin, acc, acc_clr,
        output busy, done, sum
    );
endinterface

// File: rtl/seg_add_acc.sv
// Multi-cycle adder: one SEG-bit ripple slice per clock with a registered carry,
// plus an accumulator that can stand in for operand B.
module seg_add_acc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input logic          clk,
    input logic          reset,
    seg_add_acc_if.slave bus
);
    localparam int unsigned NSEG = WIDTH / SEG;
    localparam int unsigned IdxW = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH:0]    sum_q, sum_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;

    logic [SEG-1:0]    seg_a, seg_b;
    logic [SEG:0]      seg_sum;
    logic [WIDTH-1:0]  res_next;

    assign seg_a   = a_q[idx_q*SEG +: SEG];
    assign seg_b   = b_q[idx_q*SEG +: SEG];
    assign seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, carry_q};

    always_comb begin
        res_next = res_q;
        res_next[idx_q*SEG +: SEG] = seg_sum[SEG-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                // Clear wins over a same-cycle accumulate read.
                if (bus.acc_clr) acc_d = '0;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.acc ? (bus.acc_clr ? '0 : acc_q) : bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                res_d   = res_next;
                carry_d = seg_sum[SEG];
                if (idx_q == IdxW'(NSEG - 1)) begin
                    sum_d   = {seg_sum[SEG], res_next};
                    acc_d   = res_next;
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
endmodule

// File: tb/tb_seg_add_acc.sv
// Directed bench for seg_add_acc: stimulus pushes expected sums, a monitor pops them on done.
module tb_seg_add_acc;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEG   = 8;
    localparam int unsigned NSEG  = WIDTH / SEG;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seg_add_acc_if #(.WIDTH(WIDTH), .SEG(SEG)) bus ();

    seg_add_acc #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [WIDTH:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got sum 0x%0h, expected no done", bus.sum);
            end else begin
                check("sum_on_done", 64'(bus.sum), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic acc, input logic clr,
                          input logic [WIDTH:0] exp, input bit intrude);
        int cyc;
        int busy_cnt;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
        bus.acc = acc; bus.acc_clr = clr;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.acc_clr = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (intrude && cyc == 2) begin
                bus.start = 1'b1; bus.a = 32'hFF; bus.b = 32'hFF;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("done_latency", 64'(cyc), 64'(NSEG));
        check("busy_cycles", 64'(busy_cnt), 64'(NSEG));
        check("busy_in_done", 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int c;
        int ndone;
        int last;
        reset = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        bus.acc = 1'b0; bus.acc_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_sum", 64'(bus.sum), 64'd0);
        reset = 1'b0;

        // Full carry ripple and plain adds
        run_op(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 33'h1_00000000, 1'b0);
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, 33'h0_ACF13568, 1'b0);
        run_op(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 33'h0, 1'b0);

        // Accumulate; b must be ignored in acc mode
        @(posedge clk); #1 bus.acc_clr = 1'b1;
        @(posedge clk); #1 bus.acc_clr = 1'b0;
        run_op(32'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 33'd5, 1'b0);
        run_op(32'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 33'd10, 1'b0);
        run_op(32'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 33'd15, 1'b0);
        run_op(32'd7, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 33'd7, 1'b0);

        // Start while busy is ignored
        run_op(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 33'd3, 1'b1);

        // Reset on the second RUN cycle aborts without done
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 32'hFFFFFFFF; bus.b = 32'd1; bus.cin = 1'b0;
        bus.acc = 1'b0;
        @(posedge clk); #1 bus.start = 1'b0;
        check("busy_before_abort", 64'(bus.busy), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_sum", 64'(bus.sum), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        run_op(32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 33'h10, 1'b0);
        run_op(32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 33'd5, 1'b0);

        // Back-to-back accumulation with wrap
        exp_q.push_back(33'h0_80000000);
        exp_q.push_back(33'h1_00000000);
        exp_q.push_back(33'h0_80000000);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.acc = 1'b1; bus.a = 32'h80000000; bus.cin = 1'b0;
        bus.acc_clr = 1'b1;
        @(posedge clk); #1 bus.acc_clr = 1'b0;
        c = 0;
        ndone = 0;
        last = 0;
        while (ndone < 3 && c < 40) begin
            if (bus.done === 1'b1) begin
                if (ndone == 0) check("b2b_first_latency", 64'(c), 64'(NSEG));
                else check("b2b_interval", 64'(c - last), 64'(NSEG + 1));
                last = c;
                ndone++;
            end
            @(posedge clk); #1;
            c++;
            if (ndone >= 2) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("b2b_done_count", 64'(ndone), 64'd3);

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
